// File: rtl/oc_bus_arbiter_pkg.sv
// oc_bus_arbiter_pkg: FSM state encodings and width helpers for the open-collector arbiter
package oc_bus_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_TURN = 2'd2} state_t;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // wide enough for both the turnaround load and the hold count
  function automatic int cnt_w(int turn, int hold);
    return $clog2((turn > hold ? turn : hold) + 1);
  endfunction
endpackage

// File: rtl/oc_rr_pick.sv
// oc_rr_pick: combinational round-robin picker, first set req at index >= ptr, wrapping
module oc_rr_pick
  import oc_bus_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx,
  output logic          valid
);
  logic [PW-1:0] hi, lo;
  logic hi_v, lo_v;
  // lowest set index overall is the wrap fallback when nothing sits at or above ptr
  always_comb begin
    hi = '0;
    lo = '0;
    hi_v = 1'b0;
    lo_v = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo = PW'(i);
        lo_v = 1'b1;
      end
      if (req[i] && PW'(i) >= ptr) begin
        hi = PW'(i);
        hi_v = 1'b1;
      end
    end
    valid = lo_v;
    idx = hi_v ? hi : lo;
    pick = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/oc_bus_arbiter.sv
// oc_bus_arbiter: round-robin owner of a wired-AND open-collector line with turnaround and foreign-driver detect
// Define OC_ARB_TIMEOUT_EN to enable the MAX_HOLD grant limit and tmo pulse.
module oc_bus_arbiter
  import oc_bus_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] dat,
  input  logic         bus_in,
  output logic [N-1:0] gnt,
  output logic [N-1:0] a_out,
  output logic         busy,
  output logic         collide,
  output logic         tmo
);
  localparam int PW = idx_w(N);
  localparam int CW = cnt_w(TURN_CYC, MAX_HOLD);
  state_t state;
  logic [PW-1:0] ptr, g, idx;
  logic [CW-1:0] cnt;
  logic [N-1:0] pick, elig;
  logic [1:0] rel;
  logic bus_q, valid, leave;
`ifdef OC_ARB_TIMEOUT_EN
  logic [N-1:0] mask;
  logic [CW-1:0] hold;
  assign elig = req & ~mask;
  assign leave = !req[g] || hold == CW'(MAX_HOLD - 1);
`else
  assign elig = req;
  assign leave = !req[g];
`endif
  oc_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req(elig),
    .ptr(ptr),
    .pick(pick),
    .idx(idx),
    .valid(valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr <= '0;
      g <= '0;
      cnt <= '0;
      gnt <= '0;
      a_out <= '1;
      busy <= 1'b0;
      collide <= 1'b0;
      tmo <= 1'b0;
      rel <= '0;
      bus_q <= 1'b1;
`ifdef OC_ARB_TIMEOUT_EN
      mask <= '0;
      hold <= '0;
`endif
    end else begin
      tmo <= 1'b0;
      bus_q <= bus_in;
      rel <= {rel[0], &a_out};
      // line low although we released it for two cycles: someone else is driving
      if (!bus_q && (&rel)) collide <= 1'b1;
`ifdef OC_ARB_TIMEOUT_EN
      mask <= mask & req;
`endif
      case (state)
        ST_IDLE: if (valid) begin
          state <= ST_GRANT;
          g <= idx;
          gnt <= pick;
          a_out <= ~(pick & ~dat);
          busy <= 1'b1;
`ifdef OC_ARB_TIMEOUT_EN
          hold <= '0;
`endif
        end
        ST_GRANT: if (leave) begin
          state <= ST_TURN;
          gnt <= '0;
          a_out <= '1;
          busy <= 1'b0;
          ptr <= g == PW'(N - 1) ? '0 : g + PW'(1);
          cnt <= CW'(TURN_CYC - 1);
`ifdef OC_ARB_TIMEOUT_EN
          if (req[g]) begin
            tmo <= 1'b1;
            mask <= (mask & req) | gnt;
          end
`endif
        end else begin
          a_out <= ~(gnt & ~dat);
`ifdef OC_ARB_TIMEOUT_EN
          hold <= hold + CW'(1);
`endif
        end
        ST_TURN: if (cnt == '0) state <= ST_IDLE;
        else cnt <= cnt - CW'(1);
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oc_bus_arbiter.sv
// tb_oc_bus_arbiter: vector-table bench with scoreboard for oc_bus_arbiter (N=4, TURN_CYC=2, MAX_HOLD=16)
module tb_oc_bus_arbiter;
  logic clk = 1'b0, rst = 1'b1, extra = 1'b0;
  logic [3:0] req = '0, dat = '0, gnt, a_out;
  logic bus_in, busy, collide, tmo;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  // four '17 gates plus an extra foreign one, outputs tied together under one pullup
  assign bus_in = (&a_out) & ~extra;
  oc_bus_arbiter #(.N(4), .TURN_CYC(2), .MAX_HOLD(16)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .dat(dat),
    .bus_in(bus_in),
    .gnt(gnt),
    .a_out(a_out),
    .busy(busy),
    .collide(collide),
    .tmo(tmo)
  );
  typedef struct {
    string name;
    logic r;
    logic [3:0] rq, d;
    logic x;
    logic [3:0] g, a;
    logic b, c, t;
  } vec_t;
  vec_t tv[$];
  vec_t sb[$];
  task automatic add(string n, logic r, logic [3:0] rq, logic [3:0] d, logic x,
                     logic [3:0] g, logic [3:0] a, logic b, logic c, logic t);
    tv.push_back('{n, r, rq, d, x, g, a, b, c, t});
  endtask
  task automatic own(string n, logic [3:0] rq, logic [3:0] o);
    add(n, 1'b0, rq, 4'h0, 1'b0, o, ~o, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic rel(string n, logic [3:0] rq);
    add(n, 1'b0, rq, 4'h0, 1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic run();
    vec_t e;
    foreach (tv[i]) begin
      rst = tv[i].r;
      req = tv[i].rq;
      dat = tv[i].d;
      extra = tv[i].x;
      sb.push_back(tv[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      tests++;
      if ({gnt, a_out, busy, collide, tmo} !== {e.g, e.a, e.b, e.c, e.t}) begin
        fails++;
        $display("FAIL %s: got gnt=%b a_out=%b busy=%b collide=%b tmo=%b, want %b %b %b %b %b",
                 e.name, gnt, a_out, busy, collide, tmo, e.g, e.a, e.b, e.c, e.t);
      end
    end
    tv.delete();
  endtask
  initial begin
    logic [3:0] o;
    add("rst0", 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 1'b0);
    add("rst1", 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 1'b0);
    add("single_d1", 1'b0, 4'b0010, 4'b1111, 1'b0, 4'b0010, 4'b1111, 1'b1, 1'b0, 1'b0);
    add("single_d0", 1'b0, 4'b0010, 4'b1101, 1'b0, 4'b0010, 4'b1101, 1'b1, 1'b0, 1'b0);
    add("single_d1b", 1'b0, 4'b0010, 4'b1111, 1'b0, 4'b0010, 4'b1111, 1'b1, 1'b0, 1'b0);
    add("single_d0b", 1'b0, 4'b0010, 4'b1101, 1'b0, 4'b0010, 4'b1101, 1'b1, 1'b0, 1'b0);
    rel("single_drop", 4'h0);
    rel("single_turn", 4'h0);
    rel("single_idle", 4'h0);
    run();
    add("rr_rst", 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      o = 4'b0001 << (k % 4);
      own("rr_grant", 4'hf, o);
      own("rr_hold1", 4'hf, o);
      own("rr_hold2", 4'hf, o);
      rel("rr_drop", 4'hf & ~o);
      rel("rr_turn", 4'hf);
      rel("rr_idle", 4'hf);
    end
    run();
    add("wrap_rst", 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 1'b0);
    own("wrap_g2", 4'b0100, 4'b0100);
    rel("wrap_drop2", 4'h0);
    rel("wrap_turn", 4'h0);
    rel("wrap_idle", 4'h0);
    own("wrap_g3", 4'b1001, 4'b1000);
    own("wrap_g3b", 4'b1001, 4'b1000);
    rel("wrap_drop3", 4'b0001);
    rel("wrap_turn0", 4'b0001);
    rel("wrap_idle0", 4'b0001);
    own("wrap_g0", 4'b0001, 4'b0001);
    rel("wrap_drop0", 4'h0);
    run();
    add("col_rst", 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 1'b0);
    rel("col_idle1", 4'h0);
    rel("col_idle2", 4'h0);
    rel("col_idle3", 4'h0);
    add("col_low1", 1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 4'hf, 1'b0, 1'b0, 1'b0);
    add("col_low2", 1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 4'hf, 1'b0, 1'b1, 1'b0);
    add("col_sticky", 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'hf, 1'b0, 1'b1, 1'b0);
    add("col_arb", 1'b0, 4'b0010, 4'h0, 1'b0, 4'b0010, 4'b1101, 1'b1, 1'b1, 1'b0);
    add("col_rel", 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'hf, 1'b0, 1'b1, 1'b0);
    add("col_clear", 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 1'b0);
    own("mid_grant", 4'b0001, 4'b0001);
    add("mid_rst", 1'b1, 4'b0001, 4'h0, 1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 1'b0);
    run();
`ifdef OC_ARB_TIMEOUT_EN
    own("tmo_g2", 4'b0100, 4'b0100);
    for (int k = 0; k < 15; k++) own("tmo_hold", 4'b0101, 4'b0100);
    add("tmo_pulse", 1'b0, 4'b0101, 4'h0, 1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 1'b1);
    rel("tmo_turn", 4'b0101);
    rel("tmo_idle", 4'b0101);
    own("tmo_g0", 4'b0101, 4'b0001);
    rel("tmo_drop0", 4'b0100);
    rel("tmo_turn0", 4'b0100);
    rel("tmo_idle0", 4'b0100);
    rel("tmo_masked", 4'b0100);
    rel("tmo_unmask", 4'h0);
    own("tmo_regrant", 4'b0100, 4'b0100);
`else
    for (int k = 0; k < 40; k++) own("hold_nolimit", 4'b0100, 4'b0100);
    rel("hold_drop", 4'h0);
`endif
    run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
